// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunk-serial datapath family.
// FSM encoding and chunk-count derivations.
package chunked_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk_of(
    input int width,
    input int chunk
  );
    return width / chunk;
  endfunction

  // Counter width never drops below one bit, even for a single chunk.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_serial_adder_fa_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells.
// One instance is time-shared across all chunks of an operand.
module fa_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             carry
);

  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carry = c;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock,
// LSB chunk first, carry held in a register between cycles.
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int CW     = cw_of(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             cout_r;
  logic             ovf_r;

  logic             accept;
  logic             step;
  logic             last;
  int               base;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cc;

  assign last   = (cnt == LAST);
  assign base   = int'(cnt) * CHUNK;
  assign ca     = op_a[base +: CHUNK];
  assign cb     = op_b[base +: CHUNK];
  assign accept = in_valid & in_ready;

  fa_chunk #(
    .CHUNK(CHUNK)
  ) u_fa (
    .a    (ca),
    .b    (cb),
    .cin  (carry),
    .sum  (cs),
    .carry(cc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: begin
        if (out_ready)
          state_nx = in_valid ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    step      = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready = 1'b1;
      (state == RUN):  step = 1'b1;
      (state == DONE): begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Subtraction folds into addition: invert b here, +1 via carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      carry <= sub | cin;
      cnt   <= '0;
    end else if (step) begin
      res[base +: CHUNK] <= cs;
      carry <= cc;
      cnt   <= cnt + CW'(1);
      if (last) begin
        cout_r <= cc;
        ovf_r  <= (op_a[WIDTH-1] == op_b[WIDTH-1])
                  && (cs[CHUNK-1] != op_a[WIDTH-1]);
      end
    end
  end

  assign sum      = res;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder at CHUNK=8, 1 and 32.
// Arithmetic reference model plus hand-computed vectors.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        iv[3];
  logic        ir[3];
  logic        ov[3];
  logic        orr[3];
  logic        cin_s[3];
  logic        sub_s[3];
  logic        co[3];
  logic        of[3];
  logic [31:0] a_s[3];
  logic [31:0] b_s[3];
  logic [31:0] s_s[3];

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(ov[0]), .out_ready(orr[0]),
    .sum(s_s[0]), .cout(co[0]), .overflow(of[0])
  );

  chunked_serial_adder #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(ov[1]), .out_ready(orr[1]),
    .sum(s_s[1]), .cout(co[1]), .overflow(of[1])
  );

  chunked_serial_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]), .sub(sub_s[2]),
    .out_valid(ov[2]), .out_ready(orr[2]),
    .sum(s_s[2]), .cout(co[2]), .overflow(of[2])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nch[3] = '{4, 32, 1};

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Returns {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic ci,
                                        input logic sb);
    logic [32:0] t;
    logic [31:0] s;
    logic        c;
    logic        v;
    longint      sr;
    if (sb) begin
      s  = x - y;
      c  = (x >= y);
      sr = longint'($signed(x)) - longint'($signed(y));
    end else begin
      t  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      s  = t[31:0];
      c  = t[32];
      sr = longint'($signed(x)) + longint'($signed(y))
           + (ci ? 64'sd1 : 64'sd0);
    end
    v = (sr > SMAX) || (sr < SMIN);
    return {v, c, s};
  endfunction

  logic [33:0] exp_r[3];
  logic        exp_v[3];
  logic        wl[3];
  int          acc_cyc[3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        exp_v[k] = 1'b0;
        wl[k]    = 1'b0;
      end else begin
        if (ov[k]) begin
          chk($sformatf("pending%0d", k), {63'd0, exp_v[k]}, 64'd1);
          if (exp_v[k])
            chk($sformatf("result%0d", k),
                {30'd0, of[k], co[k], s_s[k]}, {30'd0, exp_r[k]});
          if (wl[k]) begin
            chk($sformatf("latency%0d", k), cyc - acc_cyc[k], nch[k] + 1);
            wl[k] = 1'b0;
          end
          chk($sformatf("rdy_done%0d", k), ir[k], orr[k]);
          if (orr[k]) exp_v[k] = 1'b0;
        end else if (exp_v[k]) begin
          chk($sformatf("rdy_run%0d", k), ir[k], 0);
        end
        if (iv[k] && ir[k]) begin
          exp_r[k]   = model(a_s[k], b_s[k], cin_s[k], sub_s[k]);
          exp_v[k]   = 1'b1;
          wl[k]      = 1'b1;
          acc_cyc[k] = cyc;
        end
      end
    end
  end

  task automatic op(input int k, input logic [31:0] x, input logic [31:0] y,
                    input logic ci, input logic sb, input int hold,
                    input bit lit, input logic [33:0] e);
    int n;
    @(posedge clk);
    #1;
    a_s[k] = x;
    b_s[k] = y;
    cin_s[k] = ci;
    sub_s[k] = sb;
    iv[k] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ir[k]) tmo($sformatf("accept%0d", k));
    @(posedge clk);
    #1 iv[k] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ov[k]) tmo($sformatf("done%0d", k));
    else if (lit) begin
      chk($sformatf("lit_sum%0d", k), s_s[k], e[31:0]);
      chk($sformatf("lit_cout%0d", k), co[k], e[32]);
      chk($sformatf("lit_ovf%0d", k), of[k], e[33]);
    end
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1 orr[k] = 1'b1;
    @(posedge clk);
    #1 orr[k] = 1'b0;
  endtask

  task automatic rand_ops(input int k, input int cnt);
    logic [31:0] x;
    logic [31:0] y;
    int m;
    for (int i = 0; i < cnt; i++) begin
      m = $urandom_range(0, 4);
      x = $urandom;
      y = $urandom;
      if (m == 0) x = 32'h7FFF_FFFF;
      if (m == 1) y = 32'h8000_0000;
      if (m == 2) y = x;
      op(k, x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         $urandom_range(0, 2), 1'b0, 34'd0);
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      orr[k] = 1'b0;
      cin_s[k] = 1'b0;
      sub_s[k] = 1'b0;
      a_s[k] = '0;
      b_s[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_ready%0d", k), ir[k], 1);
      chk($sformatf("rst_sum%0d", k), s_s[k], 0);
      chk($sformatf("rst_cout%0d", k), co[k], 0);
      chk($sformatf("rst_ovf%0d", k), of[k], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rel_ready%0d", k), ir[k], 1);
      chk($sformatf("rel_valid%0d", k), ov[k], 0);
    end

    for (int k = 0; k < 3; k++) begin
      op(k, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1'b1,
         {1'b0, 1'b1, 32'h0000_0000});
      op(k, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1'b1,
         {1'b1, 1'b0, 32'h8000_0000});
      op(k, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1, 1'b1,
         {1'b1, 1'b1, 32'h7FFF_FFFF});
    end
    op(0, 32'h5, 32'h7, 1'b1, 1'b1, 0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2, 1'b1,
       {1'b0, 1'b1, 32'hFFFF_FFFF});

    // Backpressure in DONE, then retire and accept on one edge.
    @(posedge clk);
    #1;
    a_s[0] = 32'd10;
    b_s[0] = 32'd20;
    cin_s[0] = 1'b0;
    sub_s[0] = 1'b0;
    iv[0] = 1'b1;
    orr[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ir[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 iv[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ov[0]) tmo("bp_done");
    repeat (3) begin
      chk("bp_sum", s_s[0], 32'd30);
      chk("bp_ready", ir[0], 0);
      chk("bp_valid", ov[0], 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    orr[0] = 1'b1;
    iv[0] = 1'b1;
    a_s[0] = 32'd1;
    b_s[0] = 32'd2;
    @(negedge clk);
    chk("b2b_ready", ir[0], 1);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", n, 4);
    chk("b2b_sum", s_s[0], 32'd3);
    @(posedge clk);
    #1 orr[0] = 1'b0;

    // Reset two cycles into RUN.
    @(posedge clk);
    #1;
    a_s[0] = 32'h1234_5678;
    b_s[0] = 32'h1111_1111;
    iv[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_valid", ov[0], 0);
    chk("mid_sum", s_s[0], 0);
    chk("mid_cout", co[0], 0);
    chk("mid_ovf", of[0], 0);
    chk("mid_ready", ir[0], 1);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_valid", ov[0], 0);
      chk("post_ready", ir[0], 1);
    end

    fork
      rand_ops(0, 1000);
      rand_ops(1, 1000);
      rand_ops(2, 1000);
    join

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
